// File: rtl/weight_load_arbiter.sv
// Round-robin arbiter sharing one weight-SRAM read port among NUM_PE PE controllers.
// Each grant issues a KSIZE-word burst from the mode bank and forwards the returned words.
module weight_load_arbiter #(
  parameter int NUM_PE = 4,
  parameter int KSIZE  = 9,
  parameter int AW     = 8,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PE-1:0] req,
  input  logic [2:0]        mod,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              wt_valid,
  output logic [DW-1:0]     wt_data,
  output logic [3:0]        wt_addr,
  output logic [NUM_PE-1:0] wt_dest,
  output logic [NUM_PE-1:0] done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_r, nxt_state_s;
  logic [1:0]        ptr_r, nxt_ptr_s;
  logic [1:0]        idx_r, nxt_idx_s;
  logic [NUM_PE-1:0] grant_r, nxt_grant_s;
  logic [2:0]        mod_lat_r, nxt_mod_lat_s;
  logic [3:0]        offset_r, nxt_offset_s;
  logic              rd_r, nxt_rd_s;
  logic [AW-1:0]     addr_r, nxt_addr_s;
  logic              vld_r, nxt_vld_s;
  logic [3:0]        waddr_r, nxt_waddr_s;
  logic [NUM_PE-1:0] dest_r, nxt_dest_s;
  logic [NUM_PE-1:0] done_r, nxt_done_s;
  logic              busy_r, nxt_busy_s;
  logic              abort_s;
  logic              found_s;
  logic [1:0]        win_s;
  int                cand_s;

  function automatic logic mode_legal(input logic [2:0] m);
    case (m)
      3'b001, 3'b010, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Bank base plus a 16-word slot per PE plus the tap offset.
  function automatic logic [AW-1:0] rd_addr(input logic [2:0] m, input logic [1:0] pe,
                                            input logic [3:0] off);
    logic [7:0] base;
    case (m)
      3'b010:  base = 8'h40;
      3'b100:  base = 8'h80;
      default: base = 8'h00;
    endcase
    return AW'(base) + AW'({pe, 4'b0000}) + AW'(off);
  endfunction

  assign abort_s = (state_r == READ) && (mod != mod_lat_r);

  // Round-robin winner: first set request at or above ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    cand_s  = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      cand_s = (int'(ptr_r) + i) % NUM_PE;
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        win_s   = 2'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_ptr_s     = ptr_r;
    nxt_idx_s     = idx_r;
    nxt_grant_s   = grant_r;
    nxt_mod_lat_s = mod_lat_r;
    nxt_offset_s  = offset_r;
    nxt_rd_s      = 1'b0;
    nxt_addr_s    = '0;
    nxt_done_s    = '0;
    nxt_busy_s    = 1'b0;
    nxt_vld_s     = rd_r && !abort_s;
    nxt_waddr_s   = nxt_vld_s ? offset_r : 4'd0;
    nxt_dest_s    = nxt_vld_s ? grant_r : '0;
    case (state_r)
      IDLE: begin
        if (found_s && mode_legal(mod)) begin
          nxt_state_s   = READ;
          nxt_idx_s     = win_s;
          nxt_grant_s   = NUM_PE'(1) << win_s;
          nxt_mod_lat_s = mod;
          nxt_offset_s  = 4'd0;
          nxt_rd_s      = 1'b1;
          nxt_addr_s    = rd_addr(mod, win_s, 4'd0);
          nxt_busy_s    = 1'b1;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      READ: begin
        if (abort_s) begin
          nxt_state_s = IDLE;
        end else if (offset_r == 4'(KSIZE - 1)) begin
          nxt_state_s = DRAIN;
          nxt_done_s  = grant_r;
          nxt_busy_s  = 1'b1;
        end else begin
          nxt_offset_s = offset_r + 4'd1;
          nxt_rd_s     = 1'b1;
          nxt_addr_s   = rd_addr(mod_lat_r, idx_r, offset_r + 4'd1);
          nxt_busy_s   = 1'b1;
        end
      end
      DRAIN: begin
        nxt_state_s = IDLE;
        nxt_ptr_s   = (idx_r == 2'(NUM_PE - 1)) ? 2'd0 : idx_r + 2'd1;
      end
      default: nxt_state_s = IDLE;
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      idx_r     <= 2'd0;
      grant_r   <= '0;
      mod_lat_r <= 3'd0;
      offset_r  <= 4'd0;
      rd_r      <= 1'b0;
      addr_r    <= '0;
      vld_r     <= 1'b0;
      waddr_r   <= 4'd0;
      dest_r    <= '0;
      done_r    <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      ptr_r     <= nxt_ptr_s;
      idx_r     <= nxt_idx_s;
      grant_r   <= nxt_grant_s;
      mod_lat_r <= nxt_mod_lat_s;
      offset_r  <= nxt_offset_s;
      rd_r      <= nxt_rd_s;
      addr_r    <= nxt_addr_s;
      vld_r     <= nxt_vld_s;
      waddr_r   <= nxt_waddr_s;
      dest_r    <= nxt_dest_s;
      done_r    <= nxt_done_s;
      busy_r    <= nxt_busy_s;
    end
  end

  // A mode change kills the current read and masks the word already in flight.
  assign mem_rd   = rd_r && !abort_s;
  assign mem_addr = addr_r;
  assign wt_valid = vld_r && !abort_s;
  assign wt_data  = rst ? mem_rdata : '0;
  assign wt_addr  = waddr_r;
  assign wt_dest  = dest_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_weight_load_arbiter.sv
// Directed self-checking bench for weight_load_arbiter: a vector table for a single
// burst plus hand sequences for round-robin, illegal mode, abort and reset.
module tb_weight_load_arbiter;

  localparam int KS = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [2:0] mod;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       wt_valid;
  logic [7:0] wt_data;
  logic [3:0] wt_addr;
  logic [3:0] wt_dest;
  logic [3:0] done;
  logic       busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] cur_req;
  logic [2:0] cur_mod;
  logic       last_rd;
  logic [7:0] last_addr;

  typedef struct {
    logic [3:0] req;
    logic [2:0] mod;
    logic       rd;
    logic [7:0] addr;
    logic       vld;
    logic [3:0] waddr;
    logic [3:0] dest;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t vt[13];

  weight_load_arbiter #(.NUM_PE(4), .KSIZE(KS), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mod(mod),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_addr(wt_addr),
    .wt_dest(wt_dest), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: memory answers last cycle's read, inputs applied, outputs settle.
  task automatic step();
    @(negedge clk);
    mem_rdata = last_rd ? mem_fn(last_addr) : 8'h00;
    req = cur_req;
    mod = cur_mod;
    #1;
    last_rd   = mem_rd;
    last_addr = mem_addr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wt_valid"}, 32'(wt_valid), 32'd0);
    chk({tag, "_wt_data"},  32'(wt_data),  32'd0);
    chk({tag, "_wt_addr"},  32'(wt_addr),  32'd0);
    chk({tag, "_wt_dest"},  32'(wt_dest),  32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // Called in cycle 0 of a grant; steps cycles 1..KS+2 (the last is the next cycle 0).
  task automatic expect_burst(input int idx, input logic [7:0] base, input logic [3:0] add);
    logic [3:0] oh;
    logic [7:0] a0;
    oh = 4'(1 << idx);
    a0 = base + 8'(idx * 16);
    for (int c = 1; c <= KS + 2; c++) begin
      if (c == KS + 2) cur_req = (cur_req & ~oh) | add;
      step();
      chk("burst_mem_rd", 32'(mem_rd), 32'(c <= KS));
      if (c <= KS) chk("burst_mem_addr", 32'(mem_addr), 32'(a0 + 8'(c - 1)));
      chk("burst_wt_valid", 32'(wt_valid), 32'(c >= 2 && c <= KS + 1));
      if (c >= 2 && c <= KS + 1) begin
        chk("burst_wt_addr", 32'(wt_addr), 32'(c - 2));
        chk("burst_wt_dest", 32'(wt_dest), 32'(oh));
        chk("burst_wt_data", 32'(wt_data), 32'(mem_fn(a0 + 8'(c - 2))));
      end
      chk("burst_done", 32'(done), 32'((c == KS + 1) ? oh : 4'd0));
      chk("burst_busy", 32'(busy), 32'(c <= KS + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cur_req = 4'd0;
    req = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_rd = 1'b0;
  endtask

  initial begin
    // Single burst, mode A, PE0: cycle-by-cycle expectations.
    vt[0]  = '{4'h1, 3'b001, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[1]  = '{4'h1, 3'b001, 1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vt[2]  = '{4'h1, 3'b001, 1'b1, 8'h01, 1'b1, 4'h0, 4'h1, 4'h0, 1'b1};
    vt[3]  = '{4'h1, 3'b001, 1'b1, 8'h02, 1'b1, 4'h1, 4'h1, 4'h0, 1'b1};
    vt[4]  = '{4'h1, 3'b001, 1'b1, 8'h03, 1'b1, 4'h2, 4'h1, 4'h0, 1'b1};
    vt[5]  = '{4'h1, 3'b001, 1'b1, 8'h04, 1'b1, 4'h3, 4'h1, 4'h0, 1'b1};
    vt[6]  = '{4'h1, 3'b001, 1'b1, 8'h05, 1'b1, 4'h4, 4'h1, 4'h0, 1'b1};
    vt[7]  = '{4'h1, 3'b001, 1'b1, 8'h06, 1'b1, 4'h5, 4'h1, 4'h0, 1'b1};
    vt[8]  = '{4'h1, 3'b001, 1'b1, 8'h07, 1'b1, 4'h6, 4'h1, 4'h0, 1'b1};
    vt[9]  = '{4'h1, 3'b001, 1'b1, 8'h08, 1'b1, 4'h7, 4'h1, 4'h0, 1'b1};
    vt[10] = '{4'h1, 3'b001, 1'b0, 8'h00, 1'b1, 4'h8, 4'h1, 4'h1, 1'b1};
    vt[11] = '{4'h0, 3'b001, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[12] = '{4'h0, 3'b001, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};

    rst = 1'b0;
    req = 4'd0;
    mod = 3'b001;
    mem_rdata = 8'hFF;
    cur_req = 4'd0;
    cur_mod = 3'b001;
    last_rd = 1'b0;
    last_addr = 8'd0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cur_req = vt[i].req;
      cur_mod = vt[i].mod;
      step();
      chk("vec_mem_rd", 32'(mem_rd), 32'(vt[i].rd));
      if (vt[i].rd) chk("vec_mem_addr", 32'(mem_addr), 32'(vt[i].addr));
      chk("vec_wt_valid", 32'(wt_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk("vec_wt_addr", 32'(wt_addr), 32'(vt[i].waddr));
        chk("vec_wt_dest", 32'(wt_dest), 32'(vt[i].dest));
        chk("vec_wt_data", 32'(wt_data), 32'(mem_fn({4'h0, vt[i].waddr})));
      end
      chk("vec_done", 32'(done), 32'(vt[i].done));
      chk("vec_busy", 32'(busy), 32'(vt[i].busy));
    end

    // All four request at once in mode B: PE0..PE3 in order.
    do_reset();
    cur_mod = 3'b010;
    cur_req = 4'b1111;
    step();
    chk("all_c0_busy", 32'(busy), 32'd0);
    expect_burst(0, 8'h40, 4'd0);
    expect_burst(1, 8'h40, 4'd0);
    expect_burst(2, 8'h40, 4'd0);
    expect_burst(3, 8'h40, 4'd0);

    // Fairness: PE0 re-requests at once while PE3 waits; PE3 must win.
    cur_req = 4'b1001;
    step();
    expect_burst(0, 8'h40, 4'b0001);
    expect_burst(3, 8'h40, 4'd0);
    expect_burst(0, 8'h40, 4'd0);

    // Illegal mode holds off the grant until mode C appears.
    cur_mod = 3'b011;
    cur_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("illegal_mem_rd", 32'(mem_rd), 32'd0);
      chk("illegal_busy", 32'(busy), 32'd0);
    end
    cur_mod = 3'b100;
    step();
    chk("illegal_c0_mem_rd", 32'(mem_rd), 32'd0);
    expect_burst(1, 8'h80, 4'd0);

    // Mode change on the 4th READ cycle of PE0 aborts; PE0 restarts in bank C.
    cur_mod = 3'b001;
    cur_req = 4'b0001;
    step();
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("abort_pre_mem_rd", 32'(mem_rd), 32'd1);
      chk("abort_pre_mem_addr", 32'(mem_addr), 32'(c - 1));
      chk("abort_pre_wt_valid", 32'(wt_valid), 32'(c >= 2));
    end
    cur_mod = 3'b100;
    step();
    chk("abort_mem_rd", 32'(mem_rd), 32'd0);
    chk("abort_wt_valid", 32'(wt_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("abort_idle_mem_rd", 32'(mem_rd), 32'd0);
    chk("abort_idle_wt_valid", 32'(wt_valid), 32'd0);
    chk("abort_idle_done", 32'(done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    expect_burst(0, 8'h80, 4'd0);

    // Reset in cycle 5 of a PE1 burst; pointer must return to PE0.
    cur_mod = 3'b001;
    cur_req = 4'b0010;
    step();
    for (int c = 1; c <= 5; c++) step();
    chk("pre_reset_mem_addr", 32'(mem_addr), 32'h14);
    #2;
    mem_rdata = 8'h5A;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    cur_req = 4'd0;
    req = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    last_rd = 1'b0;
    cur_req = 4'b0011;
    step();
    expect_burst(0, 8'h00, 4'd0);
    expect_burst(1, 8'h00, 4'd0);
    step();
    chk("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_load_arbiter.md
# weight_load_arbiter

Shares one weight-memory read port among NUM_PE processing-element controllers, each needing a KSIZE-word weight burst before its filter can process. Requesters are granted round-robin, one whole burst at a time. For each grant the block generates memory addresses from the active mode bank, then forwards the returned words with destination and tap index. It sits between the PE controllers and the weight SRAM.

## Interface
- NUM_PE, 4: number of requesting PEs; must be at most 4.
- KSIZE, 9: weights per burst (3x3 kernel); must be at most 16.
- AW, 8: memory address width.
- DW, 8: weight data width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_PE  level request per PE; held until its done pulse.
- mod  in  3  one-hot mode: 001 = A, 010 = B, 100 = C.
- mem_rd  out  1  read strobe to weight SRAM.
- mem_addr  out  AW  read address.
- mem_rdata  in  DW  read data, valid exactly 1 cycle after mem_rd.
- wt_valid  out  1  wt_data/wt_addr/wt_dest valid.
- wt_data  out  DW  weight word, equal to mem_rdata.
- wt_addr  out  4  tap index 0..KSIZE-1.
- wt_dest  out  NUM_PE  one-hot destination PE.
- done  out  NUM_PE  one-cycle one-hot pulse when a PE's burst completes.
- busy  out  1  high in READ and DRAIN.

## Operation
- States: IDLE, READ, DRAIN.
- **IDLE**
  - If any req bit is set and mod is legal one-hot: pick the winner, latch the winner as grant, latch mod as mod_lat, clear offset, go to READ.
  - Illegal mod (not one-hot, including 000): no grant; requests stay pending.
- **Winner selection:** first set req bit scanning upward from pointer ptr, wrapping at NUM_PE.
- **READ**
  - Each cycle: mem_rd = 1; mem_addr = base + grant_idx*16 + offset; offset increments.
  - Bases: A = 0x00, B = 0x40, C = 0x80.
  - Go to DRAIN after issuing offset KSIZE-1.
- **DRAIN**
  - Lasts one cycle; the last word returns.
  - done[grant] = 1; ptr = (grant_idx+1) mod NUM_PE; go to IDLE.
- **Data return path**
  - wt_valid = mem_rd delayed one cycle.
  - wt_addr = offset delayed one cycle; wt_dest = grant delayed one cycle; wt_data = mem_rdata.
- **Abort:** if mod != mod_lat during READ:
  - Drop mem_rd in that same cycle and go to IDLE.
  - No done pulse; ptr unchanged.
  - The read already in flight returns with wt_valid forced to 0.
  - The PE keeps req high and is re-granted from offset 0.
- **Request changes mid-burst**
  - req deasserted during READ/DRAIN is ignored; the burst completes and done fires.
  - New requests arriving during a burst wait for IDLE.
- **Reset (async, any time):**
  - Return to IDLE with ptr = 0.
  - All outputs 0: mem_rd, mem_addr, wt_valid, wt_data, wt_addr, wt_dest, done, busy.
  - In-flight data is discarded.

## Timing
- All outputs are registered except wt_data, which passes mem_rdata straight through.
- Cycle numbering: req seen in IDLE at edge 0.
  - Cycles 1..KSIZE: READ, mem_rd high.
  - Cycles 2..KSIZE+1: wt_valid high.
  - Cycle KSIZE+1: DRAIN, carrying the last wt_valid and the done pulse.
  - Cycle KSIZE+2: IDLE.
- Grant-to-grant period is KSIZE+2 cycles (11 for KSIZE = 9).
- Exactly KSIZE wt_valid beats per completed burst, with wt_addr ascending 0..KSIZE-1 and no gaps.
- mod is sampled every cycle; an abort takes effect in the cycle mod differs from mod_lat.

## Test plan
- **Single request:** mod = 001, req = 0001.
  - mem_addr 0x00..0x08 on 9 consecutive cycles.
  - wt_valid for 9 cycles with wt_dest = 0001 and wt_addr 0..8.
  - done = 0001 in cycle 10; busy low in cycle 11.
- **All requests at once:** mod = 010, req = 1111 held.
  - Grant order is PE0, PE1, PE2, PE3, each 11 cycles apart.
  - PE2 addresses run 0x60..0x68.
  - Each done pulse fires once; req bits drop after their done.
- **Fairness:** PE0 re-requests immediately after its done while PE3 is waiting; PE3 is granted next.
- **Illegal mode:** mod = 011 with req = 0010.
  - mem_rd stays 0 and busy stays 0.
  - Setting mod = 100 yields a grant with addresses 0x90..0x98.
- **Mode change mid-burst:** mod switches from 001 to 100 at the 4th READ cycle.
  - mem_rd drops that cycle; no done; the returned word is masked.
  - Two cycles later a fresh burst to the same PE starts at base 0x80 + idx*16, offset 0.
- **Reset mid-burst:** rst low during cycle 5 of a burst.
  - All outputs are 0 immediately and ptr = 0.
  - After release with req = 0011, PE0 is granted first.
